// File: rtl/sid_bus_if.sv
// Host-side end of the SID register bus: synchronises the asynchronous 6581 pin bus
// onto clk, turns writes into one-clk strobes and answers reads from ports or the bus latch.
module sid_bus_if #(
    parameter int SYNC_STAGES  = 2,
    parameter int DECAY_CYCLES = 2000,
    localparam int DCW         = $clog2(DECAY_CYCLES + 1)
) (
    input  logic           clk,
    input  logic           iRstN,
    input  logic           clkEn,
    input  logic           iPhi2,
    input  logic           iCSn,
    input  logic           iRW,
    input  logic [4:0]     iAddr,
    input  logic [7:0]     iDataIn,
    output logic [7:0]     oDataOut,
    output logic           oDataOE,
    input  logic [7:0]     iPotX,
    input  logic [7:0]     iPotY,
    input  logic [7:0]     iOsc3,
    input  logic [7:0]     iEnv3,
    output logic           oWE,
    output logic [4:0]     oAddr,
    output logic [7:0]     oData,
    output logic [1:0]     oDbgState,
    output logic [DCW-1:0] oDbgDecay
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COMMIT = 2'd2
    } busStateT;

    // Bundle layout: {phi2, nCS, rw, addr[4:0], data[7:0]}; all pins share one
    // pipeline so every stage stays aligned. nCS resets to its idle (high) level.
    localparam int             BW       = 16;
    localparam logic [BW-1:0]  SYNC_RST = 16'h4000;

    logic [BW-1:0] syncPipe [SYNC_STAGES];
    logic [BW-1:0] syncOut;
    logic          sPhi2;
    logic          sCSn;
    logic          sRW;
    logic [4:0]    sAddr;
    logic [7:0]    sData;
    logic          phi2Lag;
    logic          phi2Fall;

    busStateT      state;
    busStateT      nextState;
    logic          capEn;
    logic          commitGo;
    logic          readDone;

    logic [4:0]    capAddr;
    logic [7:0]    capData;
    logic          capRw;

    logic [7:0]    rdValue;
    logic          rdIsPort;
    logic          roWrite;
    logic [7:0]    busLatch;
    logic [DCW-1:0] decayCnt;
    logic          latchLoad;
    logic [7:0]    latchVal;

    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                syncPipe[i] <= SYNC_RST;
            end
            phi2Lag <= 1'b0;
        end else begin
            syncPipe[0] <= {iPhi2, iCSn, iRW, iAddr, iDataIn};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                syncPipe[i] <= syncPipe[i-1];
            end
            phi2Lag <= sPhi2;
        end
    end

    assign syncOut  = syncPipe[SYNC_STAGES-1];
    assign sPhi2    = syncOut[15];
    assign sCSn     = syncOut[14];
    assign sRW      = syncOut[13];
    assign sAddr    = syncOut[12:8];
    assign sData    = syncOut[7:0];
    assign phi2Fall = phi2Lag & ~sPhi2;

    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A phi2 fall takes priority over a chip-select release seen in the same clk.
    always_comb begin
        nextState = state;
        capEn     = 1'b0;
        commitGo  = 1'b0;
        readDone  = 1'b0;
        case (state)
            IDLE: begin
                if (sPhi2 && !sCSn) begin
                    nextState = ACTIVE;
                    capEn     = 1'b1;
                end
            end
            ACTIVE: begin
                if (phi2Fall) begin
                    if (capRw) begin
                        nextState = IDLE;
                        readDone  = 1'b1;
                    end else begin
                        nextState = COMMIT;
                        commitGo  = 1'b1;
                    end
                end else if (sCSn) begin
                    nextState = IDLE;
                end else begin
                    capEn = 1'b1;
                end
            end
            COMMIT: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            capAddr <= 5'h00;
            capData <= 8'h00;
            capRw   <= 1'b0;
        end else if (capEn) begin
            capAddr <= sAddr;
            capData <= sData;
            capRw   <= sRW;
        end
    end

    always_comb begin
        rdValue  = busLatch;
        rdIsPort = 1'b1;
        case (capAddr)
            5'h19:   rdValue = iPotX;
            5'h1A:   rdValue = iPotY;
            5'h1B:   rdValue = iOsc3;
            5'h1C:   rdValue = iEnv3;
            default: rdIsPort = 1'b0;
        endcase
    end

    assign roWrite = (capAddr >= 5'h19);

    // The strobe is registered on the edge that enters COMMIT, so it is high
    // exactly while the FSM sits in COMMIT and can never repeat back to back.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            oWE   <= 1'b0;
            oAddr <= 5'h00;
            oData <= 8'h00;
        end else begin
            oWE <= commitGo && !roWrite;
            if (commitGo && !roWrite) begin
                oAddr <= capAddr;
                oData <= capData;
            end
        end
    end

    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            oDataOE  <= 1'b0;
            oDataOut <= 8'h00;
        end else begin
            oDataOE <= (state == ACTIVE) && capRw;
            if ((state == ACTIVE) && capRw) begin
                oDataOut <= rdValue;
            end
        end
    end

    assign latchLoad = commitGo || (readDone && rdIsPort);
    assign latchVal  = commitGo ? capData : rdValue;

    // A load in the same clk as the final decay tick wins over the clear.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            busLatch <= 8'h00;
            decayCnt <= '0;
        end else if (latchLoad) begin
            busLatch <= latchVal;
            decayCnt <= DCW'(DECAY_CYCLES);
        end else if (clkEn && (decayCnt != '0)) begin
            decayCnt <= decayCnt - 1'b1;
            if (decayCnt == DCW'(1)) begin
                busLatch <= 8'h00;
            end
        end
    end

    assign oDbgState = state;
    assign oDbgDecay = decayCnt;

endmodule

// File: tb/tb_sid_bus_if.sv
// Directed bench for sid_bus_if: bus-cycle driver tasks push expected strobes and
// read data into queues; a negedge monitor pops and compares whenever the DUT responds.
module tb_sid_bus_if;

    localparam int SYNC  = 2;
    localparam int DECAY = 8;

    logic       clk     = 1'b0;
    logic       iRstN   = 1'b0;
    logic       clkEn   = 1'b0;
    logic       iPhi2   = 1'b0;
    logic       iCSn    = 1'b1;
    logic       iRW     = 1'b1;
    logic [4:0] iAddr   = 5'h00;
    logic [7:0] iDataIn = 8'h00;
    logic [7:0] iPotX   = 8'h12;
    logic [7:0] iPotY   = 8'h34;
    logic [7:0] iOsc3   = 8'h00;
    logic [7:0] iEnv3   = 8'h56;
    logic [7:0] oDataOut;
    logic       oDataOE;
    logic       oWE;
    logic [4:0] oAddr;
    logic [7:0] oData;
    logic [1:0] oDbgState;
    logic [3:0] oDbgDecay;

    sid_bus_if #(.SYNC_STAGES(SYNC), .DECAY_CYCLES(DECAY)) dut (
        .clk(clk), .iRstN(iRstN), .clkEn(clkEn),
        .iPhi2(iPhi2), .iCSn(iCSn), .iRW(iRW), .iAddr(iAddr), .iDataIn(iDataIn),
        .oDataOut(oDataOut), .oDataOE(oDataOE),
        .iPotX(iPotX), .iPotY(iPotY), .iOsc3(iOsc3), .iEnv3(iEnv3),
        .oWE(oWE), .oAddr(oAddr), .oData(oData),
        .oDbgState(oDbgState), .oDbgDecay(oDbgDecay)
    );

    always #5 clk = ~clk;

    int          vecCount  = 0;
    int          missCount = 0;
    logic [12:0] wrExpQ[$];
    logic [7:0]  rdExpQ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe and every rising output-enable must match the next queued expectation.
    logic        weLag = 1'b0;
    logic        oeLag = 1'b0;
    logic [12:0] wrExp;
    logic [7:0]  rdExp;
    always @(negedge clk) begin
        if (iRstN) begin
            if (oWE) begin
                check("we_single_cycle", 32'(weLag), 0);
                if (wrExpQ.size() == 0) begin
                    vecCount++;
                    missCount++;
                    $display("FAIL we_unexpected: got strobe addr 0x%0h data 0x%0h, expected none", oAddr, oData);
                end else begin
                    wrExp = wrExpQ.pop_front();
                    check("we_addr_data", 32'({oAddr, oData}), 32'(wrExp));
                end
            end
            if (oDataOE && !oeLag) begin
                if (rdExpQ.size() == 0) begin
                    vecCount++;
                    missCount++;
                    $display("FAIL oe_unexpected: got read data 0x%0h, expected no read", oDataOut);
                end else begin
                    rdExp = rdExpQ.pop_front();
                    check("read_data", 32'(oDataOut), 32'(rdExp));
                end
            end
        end
        weLag <= oWE;
        oeLag <= oDataOE;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); clkEn = 1'b1;
            @(negedge clk); clkEn = 1'b0;
        end
    endtask

    // Write cycle; checks the strobe lands exactly 3 clks after the phi2 fall.
    // tickAtCommit raises clkEn on the commit edge.
    task automatic busWrite(input logic [4:0] addr, input logic [7:0] data, input logic tickAtCommit);
        @(negedge clk);
        iCSn = 1'b0; iRW = 1'b0; iAddr = addr; iDataIn = data;
        if (addr < 5'h19) wrExpQ.push_back({addr, data});
        repeat (2) @(negedge clk);
        iPhi2 = 1'b1;
        repeat (6) @(negedge clk);
        iPhi2 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("we_latency", 32'(oWE), 32'((k == 3) && (addr < 5'h19)));
            if (k == 2) clkEn = tickAtCommit;
            if (k == 3) clkEn = 1'b0;
        end
        if (tickAtCommit) check("decay_reload_on_collide", 32'(oDbgDecay), DECAY);
        iCSn = 1'b1; iRW = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic busRead(input logic [4:0] addr, input logic [7:0] exp);
        rdExpQ.push_back(exp);
        @(negedge clk);
        iCSn = 1'b0; iRW = 1'b1; iAddr = addr;
        repeat (2) @(negedge clk);
        iPhi2 = 1'b1;
        repeat (6) @(negedge clk);
        check("read_oe_phi2_high", 32'(oDataOE), 1);
        check("read_data_phi2_high", 32'(oDataOut), 32'(exp));
        iPhi2 = 1'b0;
        repeat (3) @(negedge clk);
        iCSn = 1'b1;
        repeat (4) @(negedge clk);
        check("read_oe_released", 32'(oDataOE), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_we", 32'(oWE), 0);
        check("rst_addr", 32'(oAddr), 0);
        check("rst_data", 32'(oData), 0);
        check("rst_dataout", 32'(oDataOut), 0);
        check("rst_oe", 32'(oDataOE), 0);
        check("rst_state", 32'(oDbgState), 0);
        check("rst_decay", 32'(oDbgDecay), 0);
        iRstN = 1'b1;
        repeat (4) @(negedge clk);

        busWrite(5'h04, 8'h41, 1'b0);

        iOsc3 = 8'hA5;
        busRead(5'h1B, 8'hA5);
        busRead(5'h00, 8'hA5);
        busRead(5'h19, 8'h12);
        busRead(5'h1C, 8'h56);
        busRead(5'h1A, 8'h34);
        busRead(5'h00, 8'h34);

        busWrite(5'h18, 8'h3C, 1'b0);
        busRead(5'h00, 8'h3C);
        tick(7);
        check("decay_one_left", 32'(oDbgDecay), 1);
        busRead(5'h00, 8'h3C);
        tick(1);
        check("decay_expired", 32'(oDbgDecay), 0);
        busRead(5'h00, 8'h00);
        tick(2);
        check("decay_saturates", 32'(oDbgDecay), 0);

        busWrite(5'h1B, 8'h77, 1'b0);
        busRead(5'h1D, 8'h77);

        tick(7);
        check("decay_before_collide", 32'(oDbgDecay), 1);
        busWrite(5'h06, 8'h99, 1'b1);
        busRead(5'h00, 8'h99);

        // Chip select released while phi2 is still high: the write must be dropped.
        @(negedge clk);
        iCSn = 1'b0; iRW = 1'b0; iAddr = 5'h07; iDataIn = 8'hEE;
        repeat (2) @(negedge clk);
        iPhi2 = 1'b1;
        repeat (4) @(negedge clk);
        iCSn = 1'b1;
        repeat (4) @(negedge clk);
        iPhi2 = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_state_idle", 32'(oDbgState), 0);
        busRead(5'h00, 8'h99);

        // Reset lands between the phi2 fall and the commit edge.
        @(negedge clk);
        iCSn = 1'b0; iRW = 1'b0; iAddr = 5'h09; iDataIn = 8'h5A;
        repeat (2) @(negedge clk);
        iPhi2 = 1'b1;
        repeat (6) @(negedge clk);
        iPhi2 = 1'b0;
        @(negedge clk);
        iRstN = 1'b0;
        #1;
        check("midrst_we", 32'(oWE), 0);
        check("midrst_addr", 32'(oAddr), 0);
        check("midrst_data", 32'(oData), 0);
        check("midrst_dataout", 32'(oDataOut), 0);
        check("midrst_oe", 32'(oDataOE), 0);
        check("midrst_state", 32'(oDbgState), 0);
        check("midrst_decay", 32'(oDbgDecay), 0);
        @(negedge clk);
        iCSn = 1'b1; iRW = 1'b1;
        repeat (2) @(negedge clk);
        iRstN = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_latch", 32'(oDbgState), 0);
        busRead(5'h00, 8'h00);

        busWrite(5'h0A, 8'h5A, 1'b0);
        busRead(5'h00, 8'h5A);

        repeat (4) @(negedge clk);
        check("wr_queue_drained", 32'(wrExpQ.size()), 0);
        check("rd_queue_drained", 32'(rdExpQ.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
